// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, flush and SYSCALL-halt sequencing for the five-stage MIPS pipeline (no forwarding),
// with cycle / stall / flush-bubble performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_wb_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_wb_reg,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             id_syscall,
  input  logic             syscall_halt,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam int unsigned DrainW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  cycle_q, stall_q, flush_q;

  logic       rs_hz, rt_hz, hz;
  logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c;
  logic       stall_inc;
  logic [1:0] flush_inc;

  // WB-stage writers are excluded: the register file writes before it is read.
  assign rs_hz = id_use_rs && (id_rs != 5'd0) &&
                 ((ex_reg_write && (ex_wb_reg == id_rs)) ||
                  (mem_reg_write && (mem_wb_reg == id_rs)));
  assign rt_hz = id_use_rt && (id_rt != 5'd0) &&
                 ((ex_reg_write && (ex_wb_reg == id_rt)) ||
                  (mem_reg_write && (mem_wb_reg == id_rt)));
  assign hz    = rs_hz || rt_hz;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_en_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 2'd0;
    case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          // Everything younger than the branch is wrong-path.
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_inc    = 2'd2;
        end else if (hz) begin
          idex_flush_c = 1'b1;
          stall_inc    = 1'b1;
        end else if (id_syscall && syscall_halt) begin
          idex_flush_c = 1'b1;
          state_d      = StDrain;
          drain_d      = DrainW'(1);
        end else if (id_jump) begin
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          flush_inc    = 2'd1;
        end else begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
        end
      end
      StDrain: begin
        idex_flush_c = 1'b1;
        drain_d      = drain_q + DrainW'(1);
        if (drain_q >= DrainW'(DRAIN_CYCLES)) begin
          state_d = StHalt;
          drain_d = '0;
        end
      end
      StHalt: begin
        if (go) begin
          // Drop the held SYSCALL from IF/ID on resume.
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = StRun;
        end
      end
      default: begin
        state_d = StRun;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q <= StRun;
      drain_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (state_q != StHalt) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (stall_inc) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      flush_q <= flush_q + CNT_W'(flush_inc);
    end
  end

  // Controls are forced low while reset is held, independent of the clock.
  assign pc_en      = CLR & pc_en_c;
  assign ifid_en    = CLR & ifid_en_c;
  assign ifid_flush = CLR & ifid_flush_c;
  assign idex_flush = CLR & idex_flush_c;

  assign halted    = (state_q == StHalt);
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, flush priority, halt sequencing,
// async reset and counter wrap (a second instance with 4-bit counters).
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       CLR;
  logic [4:0] id_rs, id_rt, ex_wb_reg, mem_wb_reg;
  logic       id_use_rs, id_use_rt, ex_reg_write, mem_reg_write;
  logic       ex_branch_taken, id_jump, id_syscall, syscall_halt, go;

  logic        pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  logic       w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_halted;
  logic [3:0] w_cycle_cnt, w_stall_cnt, w_flush_cnt;

  logic [3:0] ctrl;
  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_flush};

  int passed = 0;
  int total  = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .CLR(CLR), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_wb_reg(ex_wb_reg), .ex_reg_write(ex_reg_write),
    .mem_wb_reg(mem_wb_reg), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .id_syscall(id_syscall),
    .syscall_halt(syscall_halt), .go(go), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_w (
    .clk(clk), .CLR(CLR), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_wb_reg(ex_wb_reg), .ex_reg_write(ex_reg_write),
    .mem_wb_reg(mem_wb_reg), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .id_syscall(id_syscall),
    .syscall_halt(syscall_halt), .go(go), .pc_en(w_pc_en), .ifid_en(w_ifid_en),
    .ifid_flush(w_ifid_flush), .idex_flush(w_idex_flush), .halted(w_halted),
    .cycle_cnt(w_cycle_cnt), .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_wb_reg = 5'd0; ex_reg_write = 1'b0; mem_wb_reg = 5'd0; mem_reg_write = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; id_syscall = 1'b0; syscall_halt = 1'b0;
    go = 1'b0;
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    id_jump = 1'b1;
    CLR = 1'b0;
    #2;
    total++; if (ctrl !== 4'b0000) $display("FAIL rst_ctrl got=%b exp=%b", ctrl, 4'b0000); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rst_halted got=%b exp=0", halted); else passed++;
    total++;
    if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0)
      $display("FAIL rst_cnts got=%0d/%0d/%0d exp=0/0/0", cycle_cnt, stall_cnt, flush_cnt);
    else passed++;
    step();
    CLR = 1'b1;
    idle_inputs();
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL rst_release_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    idle_inputs();
    id_use_rs = 1'b1; id_rs = 5'd1; ex_reg_write = 1'b1; ex_wb_reg = 5'd1;
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL lu_ex_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    step();
    ex_reg_write = 1'b0; ex_wb_reg = 5'd0; mem_reg_write = 1'b1; mem_wb_reg = 5'd1;
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL lu_mem_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    step();
    mem_reg_write = 1'b0; mem_wb_reg = 5'd0;
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL lu_clear_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    total++; if (stall_cnt !== 32'd2) $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt); else passed++;
    total++; if (cycle_cnt !== 32'd2) $display("FAIL lu_cycle_cnt got=%0d exp=2", cycle_cnt); else passed++;
    // $0 is never a hazard.
    id_rs = 5'd0; ex_reg_write = 1'b1; ex_wb_reg = 5'd0;
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL lu_r0_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    // Match on a field the instruction does not read.
    id_use_rs = 1'b0; id_rs = 5'd7; ex_wb_reg = 5'd7;
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL lu_unused_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    // rt hazard against MEM writer.
    ex_reg_write = 1'b0; id_use_rt = 1'b1; id_rt = 5'd5; mem_reg_write = 1'b1; mem_wb_reg = 5'd5;
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL lu_rt_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    step();
    idle_inputs();
    #1;
    total++; if (stall_cnt !== 32'd3) $display("FAIL lu_rt_stall_cnt got=%0d exp=3", stall_cnt); else passed++;
  endtask

  task automatic test_branch_priority();
    do_reset();
    idle_inputs();
    ex_branch_taken = 1'b1; id_jump = 1'b1; id_syscall = 1'b1; syscall_halt = 1'b1;
    id_use_rs = 1'b1; id_rs = 5'd3; ex_reg_write = 1'b1; ex_wb_reg = 5'd3;
    #1;
    total++; if (ctrl !== 4'b1111) $display("FAIL br_ctrl got=%b exp=%b", ctrl, 4'b1111); else passed++;
    step();
    idle_inputs();
    #1;
    total++; if (stall_cnt !== 32'd0) $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    total++; if (flush_cnt !== 32'd2) $display("FAIL br_flush_cnt got=%0d exp=2", flush_cnt); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL br_no_drain got=%b exp=0", halted); else passed++;
    total++; if (ctrl !== 4'b1100) $display("FAIL br_after_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
  endtask

  task automatic test_jump();
    do_reset();
    idle_inputs();
    id_jump = 1'b1;
    #1;
    total++; if (ctrl !== 4'b1110) $display("FAIL jmp_ctrl got=%b exp=%b", ctrl, 4'b1110); else passed++;
    step();
    total++; if (flush_cnt !== 32'd1) $display("FAIL jmp_flush_cnt got=%0d exp=1", flush_cnt); else passed++;
    // A hazard holds the jump in ID.
    id_use_rt = 1'b1; id_rt = 5'd9; ex_reg_write = 1'b1; ex_wb_reg = 5'd9;
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL jmp_hz_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    step();
    idle_inputs();
    #1;
    total++; if (flush_cnt !== 32'd1) $display("FAIL jmp_hz_flush_cnt got=%0d exp=1", flush_cnt); else passed++;
    total++; if (stall_cnt !== 32'd1) $display("FAIL jmp_hz_stall_cnt got=%0d exp=1", stall_cnt); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    idle_inputs();
    id_syscall = 1'b1;
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL sys_nohalt_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    step();
    syscall_halt = 1'b1;
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL sys_halt_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    step();
    go = 1'b1;  // go outside HALT must be ignored
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++;
      if ({ctrl, halted} !== 5'b00010)
        $display("FAIL drain%0d ctrl/halted got=%b/%b exp=0001/0", i, ctrl, halted);
      else passed++;
      step();
    end
    go = 1'b0;
    #1;
    total++; if (halted !== 1'b1) $display("FAIL halt_halted got=%b exp=1", halted); else passed++;
    total++; if (ctrl !== 4'b0000) $display("FAIL halt_ctrl got=%b exp=%b", ctrl, 4'b0000); else passed++;
    total++; if (cycle_cnt !== 32'd5) $display("FAIL halt_cycle_cnt got=%0d exp=5", cycle_cnt); else passed++;
    step();
    total++; if (cycle_cnt !== 32'd5) $display("FAIL halt_frozen got=%0d exp=5", cycle_cnt); else passed++;
    go = 1'b1;
    #1;
    total++; if (ctrl !== 4'b1110) $display("FAIL go_ctrl got=%b exp=%b", ctrl, 4'b1110); else passed++;
    step();
    idle_inputs();
    #1;
    total++; if (halted !== 1'b0) $display("FAIL resume_halted got=%b exp=0", halted); else passed++;
    total++; if (ctrl !== 4'b1100) $display("FAIL resume_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    total++; if (flush_cnt !== 32'd0) $display("FAIL resume_flush_cnt got=%0d exp=0", flush_cnt); else passed++;
    step();
    total++; if (cycle_cnt !== 32'd6) $display("FAIL resume_cycle_cnt got=%0d exp=6", cycle_cnt); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    idle_inputs();
    id_syscall = 1'b1; syscall_halt = 1'b1;
    step();
    step();
    #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL ar_pre_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    CLR = 1'b0;
    #1;
    total++; if (ctrl !== 4'b0000) $display("FAIL ar_ctrl got=%b exp=%b", ctrl, 4'b0000); else passed++;
    total++; if (cycle_cnt !== 32'd0) $display("FAIL ar_cycle_cnt got=%0d exp=0", cycle_cnt); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL ar_halted got=%b exp=0", halted); else passed++;
    step();
    CLR = 1'b1;
    idle_inputs();
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL ar_release_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    step();
    step();
    step();
    total++; if (halted !== 1'b0) $display("FAIL ar_run_halted got=%b exp=0", halted); else passed++;
    total++; if (cycle_cnt !== 32'd3) $display("FAIL ar_run_cycle_cnt got=%0d exp=3", cycle_cnt); else passed++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    idle_inputs();
    for (int i = 0; i < 15; i++) step();
    total++; if (w_cycle_cnt !== 4'd15) $display("FAIL wrap_pre got=%0d exp=15", w_cycle_cnt); else passed++;
    step();
    total++; if (w_cycle_cnt !== 4'd0) $display("FAIL wrap_cycle_cnt got=%0d exp=0", w_cycle_cnt); else passed++;
    total++; if (cycle_cnt !== 32'd16) $display("FAIL wrap_wide_cnt got=%0d exp=16", cycle_cnt); else passed++;
    // 4-bit flush counter: 8 taken branches add 16 and wrap back to 0.
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 7; i++) step();
    total++; if (w_flush_cnt !== 4'd14) $display("FAIL wrap_flush_pre got=%0d exp=14", w_flush_cnt); else passed++;
    step();
    total++; if (w_flush_cnt !== 4'd0) $display("FAIL wrap_flush_cnt got=%0d exp=0", w_flush_cnt); else passed++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    CLR = 1'b1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_jump();
    test_halt();
    test_async_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the five-stage MIPS pipeline.
- Detects RAW hazards between the ID stage and in-flight EX/MEM writers. The pipeline has no forwarding.
- Generates PC / IF-ID enables and IF-ID / ID-EX flushes for stalls, taken branches (resolved in EX) and jumps (resolved in ID).
- Sequences a SYSCALL halt: drain, halt, resume.
- Keeps cycle, stall and flush-bubble performance counters.

Parameters:
- DRAIN_CYCLES, 3, number of cycles fetch is frozen after a halting SYSCALL so older instructions retire through WB.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset; asynchronous, active-low.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_wb_reg  in  5  destination register of instruction in EX.
- ex_reg_write  in  1  EX instruction writes register file.
- mem_wb_reg  in  5  destination register of instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes register file.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- id_jump  in  1  J/JAL/JR in ID.
- id_syscall  in  1  SYSCALL in ID.
- syscall_halt  in  1  SYSCALL in ID requests halt ($v0==10); qualified by id_syscall.
- go  in  1  resume request; honoured only in HALT.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load bubble into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- halted  out  1  pipeline halted.
- cycle_cnt  out  CNT_W  non-halted cycles.
- stall_cnt  out  CNT_W  RAW stall cycles.
- flush_cnt  out  CNT_W  bubbles inserted by branch/jump flushes.

Behaviour:
- State: RUN, DRAIN, HALT, plus a drain counter of ceil(log2(DRAIN_CYCLES+1)) bits.
- CLR low, immediate and asynchronous:
  - state=RUN, drain counter=0, all counters=0, halted=0.
  - pc_en=ifid_en=ifid_flush=idex_flush=0 while CLR is low.
- Outputs are combinational from the registered state and the current inputs, so they act in the same cycle. halted is registered (=1 iff state==HALT).
- Hazard condition:
  - hz = (id_use_rs && id_rs!=0 && ((ex_reg_write && ex_wb_reg==id_rs) || (mem_reg_write && mem_wb_reg==id_rs))), OR the same test for rt.
  - WB-stage writers are not hazards; the register file writes before it is read.
- RUN, evaluated in strict priority order:
  1. ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; flush_cnt+=2. hz, id_jump and id_syscall are ignored because they are wrong-path.
  2. hz: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; stall_cnt+=1. id_syscall and id_jump are held until the hazard clears.
  3. id_syscall && syscall_halt:
     - pc_en=0, ifid_en=0, idex_flush=1.
     - Next state DRAIN, drain counter=1.
  4. id_jump: pc_en=1, ifid_en=1, ifid_flush=1; flush_cnt+=1.
  5. Otherwise: pc_en=1, ifid_en=1, no flushes.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_flush=1. All other inputs are ignored.
  - Counter increments each cycle. When counter==DRAIN_CYCLES, next state is HALT.
- HALT:
  - All enables and flushes are 0; counters frozen.
  - If go=1: that cycle pc_en=1, ifid_en=1, ifid_flush=1 (discards the held SYSCALL), and next state is RUN. This cycle is not counted in flush_cnt.
- cycle_cnt increments every cycle with state!=HALT, including DRAIN.
- All counters wrap modulo 2^CNT_W with no saturation.
- go outside HALT has no effect.
- CLR asserted in any state returns to RUN at once; the counters are lost.

Test Plan:
- Load-use stall: lw $1 in EX with ex_reg_write=1, ex_wb_reg=1; ID add reads rs=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 2 cycles (EX then MEM); stall_cnt=2; no stall when id_rs=0 with ex_wb_reg=0.
- Taken branch with simultaneous hazard and jump: ex_branch_taken=1, hz=1, id_jump=1 -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged; flush_cnt+=2.
- Jump: id_jump=1 alone -> ifid_flush=1, idex_flush=0, pc_en=1; flush_cnt=1 after one jump.
- Halt sequence: id_syscall=1, syscall_halt=1 -> DRAIN for 3 cycles with pc_en=0, halted=1 on the 4th cycle; cycle_cnt frozen; go pulse -> pc_en=1, ifid_flush=1 that cycle, then normal RUN; SYSCALL with syscall_halt=0 -> no effect.
- Async reset mid-DRAIN: drop CLR between edges -> outputs 0 immediately, halted=0, counters 0; after release, RUN with pc_en=1.
- Counter wrap: CNT_W=4, 16 RUN cycles -> cycle_cnt returns to 0.
